// File: rtl/loa_seq_ctrl_if.sv
// Operand/result handshake bundle for the LOA sequencer.
// master drives operands and accepts results; slave is the sequencer.
interface loa_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/loa_seq_ctrl.sv
// Chunk-serial lower-part-OR approximate adder sequencer.
// One CHUNK-bit slice per cycle; OR cells below APPROX in LOA mode.
module loa_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int APPROX = 4,
  parameter int CIN_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  loa_seq_ctrl_if.slave  bus,
  output logic           busy
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("loa_seq_ctrl: WIDTH must be a positive multiple of CHUNK");
  end
  if (APPROX < 0 || APPROX > WIDTH) begin : g_bad_approx
    $error("loa_seq_ctrl: APPROX out of range");
  end
  if (CIN_EN != 0 && CIN_EN != 1) begin : g_bad_cin
    $error("loa_seq_ctrl: CIN_EN must be 0 or 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             armed_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             mode_q;
  logic             carry_q;
  logic             cout_q;
  logic [KW-1:0]    k_q;

  logic             accept;
  logic             last;
  logic             cin;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             cy;

  // Carry injected at bit APPROX from the top approximate bit pair
  if (CIN_EN == 1 && APPROX > 0) begin : g_cin
    assign cin = bus.approx_en
               & bus.a[APPROX-1]
               & bus.b[APPROX-1];
  end else begin : g_nocin
    assign cin = 1'b0;
  end

  assign last     = (k_q == KW'(NCH - 1));
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    busy          = 1'b1;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = armed_q;
        if (bus.in_valid && armed_q) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared slice: approximate bits pass the carry through untouched
  always_comb begin
    a_c = a_q[int'(k_q)*CHUNK +: CHUNK];
    b_c = b_q[int'(k_q)*CHUNK +: CHUNK];
    s_c = '0;
    cy  = carry_q;
    for (int j = 0; j < CHUNK; j++) begin
      if (mode_q && (int'(k_q)*CHUNK + j < APPROX)) begin
        s_c[j] = a_c[j] | b_c[j];
      end else begin
        s_c[j] = a_c[j] ^ b_c[j] ^ cy;
        cy     = (a_c[j] & b_c[j])
               | (cy & (a_c[j] ^ b_c[j]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        mode_q  <= bus.approx_en;
        carry_q <= cin;
        k_q     <= '0;
      end else if (state_q == RUN) begin
        sum_q[int'(k_q)*CHUNK +: CHUNK] <= s_c;
        carry_q <= cy;
        k_q     <= last ? '0 : k_q + 1'b1;
        if (last) cout_q <= cy;
      end
    end
  end
endmodule

// File: tb/tb_loa_seq_ctrl.sv
// Directed and random checks for loa_seq_ctrl.
// WIDTH=16, CHUNK=4, APPROX=4, CIN_EN=1.
module tb_loa_seq_ctrl;
  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int AP  = 4;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_run;
  int   n_fail;

  loa_seq_ctrl_if #(.WIDTH(W)) bus ();

  loa_seq_ctrl #(
    .WIDTH(W), .CHUNK(4), .APPROX(AP), .CIN_EN(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] loa_ref(
    input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-AP:0] up;
    logic [AP-1:0] lo;
    logic          ci;
    lo = a[AP-1:0] | b[AP-1:0];
    ci = a[AP-1] & b[AP-1];
    up = (W-AP+1)'(a[W-1:AP]) + (W-AP+1)'(b[W-1:AP])
       + (W-AP+1)'(ci);
    return {up, lo};
  endfunction

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic m);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.a = a; bus.b = b; bus.approx_en = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.approx_en = ~m;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take(output logic [W:0] r);
    r = {bus.cout, bus.sum};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic xact(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic m,
                      output logic [W:0] r,
                      output int lat);
    send(a, b, m);
    wait_out(lat);
    take(r);
  endtask

  logic [W:0]   r;
  logic [W:0]   e;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  int           lat;
  int           bad_x;
  int           bad_l;

  initial begin
    n_run = 0; n_fail = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.approx_en = 1'b0;
    rst_n = 1'b0;
    #23;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    xact(16'h000F, 16'h0001, 1'b1, r, lat);
    chk("t1_loa", 32'(r), 32'h0000F);
    chk("t1_lat", 32'(lat), 32'(NCH));
    xact(16'h000F, 16'h0001, 1'b0, r, lat);
    chk("t2_exact", 32'(r), 32'h00010);
    xact(16'hFFFF, 16'h0008, 1'b1, r, lat);
    chk("t3_ripple", 32'(r), 32'h1000F);
    xact(16'hFFFF, 16'h0001, 1'b0, r, lat);
    chk("t3b_exact_ovf", 32'(r), 32'h10000);

    send(16'h1234, 16'h4321, 1'b0);
    chk("t4_busy", 32'(busy), 32'd1);
    wait_out(lat);
    chk("t4_lat", 32'(lat), 32'(NCH));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      @(posedge clk); #1;
      chk("t4_hold_sum", 32'({bus.cout, bus.sum}), 32'h05555);
      chk("t4_hold_rdy", 32'(bus.in_ready), 32'd0);
      chk("t4_hold_ov", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    take(r);
    chk("t4_result", 32'(r), 32'h05555);
    chk("t4_ov_drop", 32'(bus.out_valid), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_keep", 32'({bus.cout, bus.sum}), 32'h05555);
    xact(16'h8000, 16'h8000, 1'b0, r, lat);
    chk("t4_next", 32'(r), 32'h10000);

    send(16'h1234, 16'h1111, 1'b1);
    @(posedge clk); #1;
    chk("t5_mid_sum", 32'(bus.sum), 32'h0005);
    rst_n = 1'b0;
    #1;
    chk("t5_ov", 32'(bus.out_valid), 32'd0);
    chk("t5_sum", 32'(bus.sum), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rdy_lo", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("t5_rdy_pre", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("t5_rdy", 32'(bus.in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_ov", 32'(bus.out_valid), 32'd0);
    xact(16'h0003, 16'h0004, 1'b1, r, lat);
    chk("t5_new", 32'(r), 32'h00007);

    bad_x = 0; bad_l = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      xact(ra, rb, 1'b0, r, lat);
      e = (W+1)'(ra) + (W+1)'(rb);
      chk("rnd_exact", 32'(r), 32'(e));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      xact(ra, rb, 1'b1, r, lat);
      chk("rnd_loa", 32'(r), 32'(loa_ref(ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
